// File: rtl/fp_div_arbiter_if.sv
// fp_div_arbiter_if: requester, response and divider-side signals of the shared FP divider arbiter.
interface fp_div_arbiter_if;
  logic        in_req0;
  logic [31:0] in_numA0;
  logic [31:0] in_numB0;
  logic        in_req1;
  logic [31:0] in_numA1;
  logic [31:0] in_numB1;
  logic        out_done0;
  logic        out_done1;
  logic [31:0] out_result;
  logic        out_timeout;
  logic        out_busy;
  logic        out_div_start;
  logic [31:0] out_div_numA;
  logic [31:0] out_div_numB;
  logic        in_div_stall;
  logic [31:0] in_div_result;
  modport slave (
    input  in_req0, in_numA0, in_numB0, in_req1, in_numA1, in_numB1, in_div_stall, in_div_result,
    output out_done0, out_done1, out_result, out_timeout, out_busy, out_div_start, out_div_numA, out_div_numB
  );
  modport master (
    output in_req0, in_numA0, in_numB0, in_req1, in_numA1, in_numB1, in_div_stall, in_div_result,
    input  out_done0, out_done1, out_result, out_timeout, out_busy, out_div_start, out_div_numA, out_div_numB
  );
endinterface

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one FP divider between two requesters,
// with start/stall sequencing, quotient capture and a watchdog abort.
module fp_div_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input logic              in_Clk,
  input logic              in_Rst_N,
  fp_div_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;
  state_t      state_q, state_d;
  logic        grant_q, grant_d, last_q, last_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [31:0] result_q, result_d, num_a_q, num_a_d, num_b_q, num_b_d;
  logic        win, expired;
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    result_d  = result_q;
    num_a_d   = num_a_q;
    num_b_d   = num_b_q;
    win       = (bus.in_req0 && bus.in_req1) ? ~last_q : bus.in_req1;
    expired   = wd_q >= CNT_W'(TIMEOUT_CYC - 1);
    case (state_q)
      IDLE: if (bus.in_req0 || bus.in_req1) begin
        grant_d   = win;
        last_d    = win;
        num_a_d   = win ? bus.in_numA1 : bus.in_numA0;
        num_b_d   = win ? bus.in_numB1 : bus.in_numB0;
        timeout_d = 1'b0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI, WAIT_LO: begin
        wd_d = (&wd_q) ? wd_q : wd_q + CNT_W'(1);
        // a real completion wins over an abort landing in the same cycle
        if (state_q == WAIT_LO && !bus.in_div_stall) begin
          result_d = bus.in_div_result;
          state_d  = RESP;
        end else if (expired) begin
          result_d  = 32'h7FC0_0000;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else if (state_q == WAIT_HI && bus.in_div_stall) begin
          state_d = WAIT_LO;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      result_q  <= '0;
      num_a_q   <= '0;
      num_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
      result_q  <= result_d;
      num_a_q   <= num_a_d;
      num_b_q   <= num_b_d;
    end
  end
  assign bus.out_done0     = (state_q == RESP) && !grant_q;
  assign bus.out_done1     = (state_q == RESP) && grant_q;
  assign bus.out_timeout   = (state_q == RESP) && timeout_q;
  assign bus.out_busy      = state_q != IDLE;
  assign bus.out_div_start = state_q == ISSUE;
  assign bus.out_result    = result_q;
  assign bus.out_div_numA  = num_a_q;
  assign bus.out_div_numB  = num_b_q;
endmodule
